// File: rtl/e1_frame_sync.sv
// rtl/e1_frame_sync.sv - E1 frame alignment recovery (FAS/NFAS/FAS acquisition, loss check)
//
// Purpose: locates TS0 in a received E1 byte stream and tags each accepted
// byte with its timeslot number and frame parity.
//
// Ports:
//   clk         in   byte clock
//   rst         in   asynchronous active-high reset
//   din[7:0]    in   received byte
//   din_valid   in   din carries a byte this cycle
//   dout[7:0]   out  registered copy of the accepted byte
//   dout_valid  out  dout valid
//   ts_num[4:0] out  timeslot index of dout
//   frame_odd   out  0 = FAS frame, 1 = NFAS frame
//   in_sync     out  frame alignment held
//   frame_start out  pulse with TS0 of an FAS frame while in_sync
//   fas_err     out  pulse when an expected alignment word is wrong

module e1_frame_sync #(
    parameter logic [6:0] FAS_WORD     = 7'h1b,
    parameter int         TS_PER_FRAME = 32,
    parameter int         LOSS_THRESH  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [4:0] ts_num,
    output logic       frame_odd,
    output logic       in_sync,
    output logic       frame_start,
    output logic       fas_err
);

    localparam int         CW      = $clog2(LOSS_THRESH + 1);
    localparam logic [4:0] TS_LAST = 5'(TS_PER_FRAME - 1);

    typedef enum logic [1:0] {SEARCH, CHK_NFAS, CHK_FAS, SYNC} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_ts;
    logic            r_par;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_err;

    logic            w_fas_ok;
    logic            w_nfas_ok;
    logic            w_hunt_hit;
    logic [4:0]      w_ts;
    logic            w_par;
    logic            w_ts0;
    logic            w_in_sync_nxt;
    logic            w_fs_nxt;

    assign w_fas_ok   = (din[6:0] == FAS_WORD);
    assign w_nfas_ok  = din[6];
    assign w_hunt_hit = (r_state == SEARCH) && w_fas_ok;

    // Position of the byte being accepted; a hunt hit redefines it as TS0 of an FAS frame.
    assign w_ts  = w_hunt_hit ? 5'd0 : r_ts;
    assign w_par = w_hunt_hit ? 1'b0 : r_par;
    assign w_ts0 = (w_ts == 5'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; only TS0 bytes are examined outside SEARCH
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err       = 1'b0;
        if (din_valid) begin
            case (r_state)
                SEARCH: begin
                    if (w_fas_ok) w_state_nxt = CHK_NFAS;
                end
                CHK_NFAS: begin
                    if (w_ts0 && w_par) begin
                        if (w_nfas_ok) begin
                            w_state_nxt = CHK_FAS;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = SEARCH;
                        end
                    end
                end
                CHK_FAS: begin
                    if (w_ts0 && !w_par) begin
                        if (w_fas_ok) begin
                            w_state_nxt = SYNC;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = SEARCH;
                        end
                    end
                end
                default: begin
                    if (w_ts0 && !w_par) begin
                        if (w_fas_ok) begin
                            w_cnt_nxt = '0;
                        end else begin
                            w_err = 1'b1;
                            if (r_cnt >= CW'(LOSS_THRESH - 1)) begin
                                w_state_nxt = SEARCH;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_cnt_nxt = r_cnt + CW'(1);
                            end
                        end
                    end else if (w_ts0 && w_par && !w_nfas_ok) begin
                        // NFAS bit errors are flagged but never count toward loss
                        w_err = 1'b1;
                    end
                end
            endcase
        end
    end

    // Output decode: alignment status reflects the decision made on this byte
    always_comb begin
        w_in_sync_nxt = (w_state_nxt == SYNC);
        w_fs_nxt      = w_in_sync_nxt && w_ts0 && !w_par;
    end

    // Counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts        <= '0;
            r_par       <= 1'b0;
            r_cnt       <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            ts_num      <= '0;
            frame_odd   <= 1'b0;
            in_sync     <= 1'b0;
            frame_start <= 1'b0;
            fas_err     <= 1'b0;
        end else begin
            dout_valid  <= din_valid;
            frame_start <= din_valid && w_fs_nxt;
            fas_err     <= w_err;
            if (din_valid) begin
                dout      <= din;
                ts_num    <= w_ts;
                frame_odd <= w_par;
                in_sync   <= w_in_sync_nxt;
                r_cnt     <= w_cnt_nxt;
                if (w_ts == TS_LAST) begin
                    r_ts  <= '0;
                    r_par <= ~w_par;
                end else begin
                    r_ts  <= w_ts + 5'd1;
                    r_par <= w_par;
                end
            end
        end
    end

endmodule
